// File: rtl/posit_encoder_pkg.sv
// Shared posit definitions: sign type, default word configuration,
// special encodings and the maxpos body helper.
package common;

    typedef enum logic {
        SIGN_POS = 1'b0,
        SIGN_NEG = 1'b1
    } sign_t;

    localparam int unsigned POSIT_N  = 16;
    localparam int unsigned POSIT_ES = 1;

    localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;
    localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};

    // Largest body (all N-1 bits set) for an n-bit posit.
    function automatic logic [63:0] maxpos_body(input int unsigned n);
        maxpos_body = (64'd1 << (n - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/posit_encoder_if.sv
// Field-side input and word-side output handshakes of the posit encoder.
interface posit_encoder_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned W_REG = 6,
    parameter int unsigned W_EXP = 2,
    parameter int unsigned W_MAN = 16
);
    import common::*;

    logic                    in_valid;
    logic                    in_ready;
    sign_t                   in_sign;
    logic signed [W_REG-1:0] in_regime;
    logic signed [W_EXP-1:0] in_exponent;
    logic        [W_MAN-1:0] in_mantissa;
    logic                    in_zero;
    logic                    in_nar;
    logic                    out_valid;
    logic                    out_ready;
    logic        [N-1:0]     out_posit;

    modport master (
        output in_valid, in_sign, in_regime, in_exponent, in_mantissa,
               in_zero, in_nar, out_ready,
        input  in_ready, out_valid, out_posit
    );

    modport slave (
        input  in_valid, in_sign, in_regime, in_exponent, in_mantissa,
               in_zero, in_nar, out_ready,
        output in_ready, out_valid, out_posit
    );

endinterface

// File: rtl/posit_encoder_round.sv
// Stage-2 combinational path: round-to-nearest-even on the kept body,
// clamp to maxpos/minpos, apply sign, then the zero/NaR overrides.
module posit_round
    import common::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-2:0] keep_i,
    input  logic         guard_i,
    input  logic         sticky_i,
    input  logic         sat_max_i,
    input  logic         sat_min_i,
    input  sign_t        sign_i,
    input  logic         zero_i,
    input  logic         nar_i,
    output logic [N-1:0] posit_o
);

    localparam logic [N-2:0] BODY_MAX = (N-1)'(maxpos_body(N));
    localparam logic [N-2:0] BODY_MIN = {{(N-2){1'b0}}, 1'b1};
    localparam logic [N-1:0] WORD_NAR = {1'b1, {(N-1){1'b0}}};

    logic         round_up;
    logic [N-1:0] sum;
    logic [N-2:0] body;
    logic [N-1:0] word;

    always_comb begin
        round_up = guard_i & (sticky_i | keep_i[0]);
        sum      = {1'b0, keep_i} + {{(N-1){1'b0}}, round_up};
        body     = sum[N-2:0];
        if (sum[N-1] || sat_max_i) begin
            body = BODY_MAX;
        end
        // A nonzero value never collapses to the zero encoding.
        if (sat_min_i || body == '0) begin
            body = BODY_MIN;
        end
        word = {1'b0, body};
        if (sign_i == SIGN_NEG) begin
            word = -word;
        end
        if (nar_i) begin
            word = WORD_NAR;
        end else if (zero_i) begin
            word = '0;
        end
        posit_o = word;
    end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage posit encoder: stage 1 builds the regime/exponent/fraction body
// and extracts keep/guard/sticky; stage 2 rounds, clamps and signs.
module posit_encoder
    import common::*;
#(
    parameter int unsigned N     = POSIT_N,
    parameter int unsigned ES    = POSIT_ES,
    parameter int unsigned W_REG = 6,
    parameter int unsigned W_EXP = 2,
    parameter int unsigned W_MAN = 16
) (
    input logic             clk,
    input logic             rst,
    posit_encoder_if.slave  bus
);

    localparam int unsigned EW       = N - 1 + W_MAN + (1 << ES) + 2;
    localparam int unsigned RW       = W_REG + 1;
    localparam int unsigned EXP_DROP = W_EXP - ES;

    localparam logic signed [RW-1:0] K_MAX    = RW'(N - 2);
    localparam logic signed [RW-1:0] K_MIN    = -K_MAX;
    localparam logic signed [RW-1:0] ONE      = RW'(1);
    localparam logic signed [RW-1:0] TWO      = RW'(2);
    localparam logic        [EW-1:0] ALL_ONES = '1;
    localparam logic        [EW-1:0] TOP_ONE  = {1'b1, {(EW-1){1'b0}}};

    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv;

    logic [N-2:0] s1_keep_q, s1_keep_d;
    logic         s1_guard_q, s1_guard_d, s1_sticky_q, s1_sticky_d;
    logic         s1_sat_max_q, s1_sat_max_d, s1_sat_min_q, s1_sat_min_d;
    logic         s1_zero_q, s1_zero_d, s1_nar_q, s1_nar_d;
    sign_t        s1_sign_q, s1_sign_d;
    logic [N-1:0] out_posit_q, out_posit_d, round_word;

    logic signed [RW-1:0] k_ext, run_len;
    logic        [EW-1:0] regime_bits, tail_bits, ext_body;

    assign s2_adv        = !s2_valid_q || bus.out_ready;
    assign s1_adv        = !s1_valid_q || s2_adv;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_posit = out_posit_q;

    // Regime run plus exponent/fraction tail, MSB at the top of the kept field.
    always_comb begin
        k_ext     = {bus.in_regime[W_REG-1], bus.in_regime};
        tail_bits = '0;
        tail_bits[EW-1 -: W_EXP+W_MAN] = {bus.in_exponent, bus.in_mantissa};
        tail_bits = tail_bits << EXP_DROP;
        if (!k_ext[RW-1]) begin
            run_len     = k_ext + TWO;
            regime_bits = ~(ALL_ONES >> unsigned'(k_ext + ONE));
        end else begin
            run_len     = ONE - k_ext;
            regime_bits = TOP_ONE >> unsigned'(-k_ext);
        end
        ext_body = regime_bits | (tail_bits >> unsigned'(run_len));
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_keep_d    = s1_keep_q;
        s1_guard_d   = s1_guard_q;
        s1_sticky_d  = s1_sticky_q;
        s1_sat_max_d = s1_sat_max_q;
        s1_sat_min_d = s1_sat_min_q;
        s1_sign_d    = s1_sign_q;
        s1_zero_d    = s1_zero_q;
        s1_nar_d     = s1_nar_q;
        if (s1_adv) begin
            s1_valid_d   = bus.in_valid;
            s1_keep_d    = ext_body[EW-1 -: N-1];
            s1_guard_d   = ext_body[EW-N];
            s1_sticky_d  = |ext_body[EW-N-1:0];
            s1_sat_max_d = k_ext > K_MAX;
            s1_sat_min_d = k_ext < K_MIN;
            s1_sign_d    = bus.in_sign;
            s1_zero_d    = bus.in_zero;
            s1_nar_d     = bus.in_nar;
        end
    end

    posit_round #(.N(N)) u_round (
        .keep_i    (s1_keep_q),
        .guard_i   (s1_guard_q),
        .sticky_i  (s1_sticky_q),
        .sat_max_i (s1_sat_max_q),
        .sat_min_i (s1_sat_min_q),
        .sign_i    (s1_sign_q),
        .zero_i    (s1_zero_q),
        .nar_i     (s1_nar_q),
        .posit_o   (round_word)
    );

    always_comb begin
        s2_valid_d  = s2_valid_q;
        out_posit_d = out_posit_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_posit_d = round_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_posit_q  <= '0;
            s1_keep_q    <= '0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_sat_max_q <= 1'b0;
            s1_sat_min_q <= 1'b0;
            s1_sign_q    <= SIGN_POS;
            s1_zero_q    <= 1'b0;
            s1_nar_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            out_posit_q  <= out_posit_d;
            s1_keep_q    <= s1_keep_d;
            s1_guard_q   <= s1_guard_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_sat_max_q <= s1_sat_max_d;
            s1_sat_min_q <= s1_sat_min_d;
            s1_sign_q    <= s1_sign_d;
            s1_zero_q    <= s1_zero_d;
            s1_nar_q     <= s1_nar_d;
        end
    end

endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Packs unpacked posit fields (sign, regime, exponent, mantissa) into an N-bit posit word. Rounding is round-to-nearest-even, with saturation.
- It is the inverse of the field-level datapath: fields produced by the ALU (after compare/align/add) are re-encoded here before writeback.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- N, 16, posit word width (>= 8)
- ES, 1, exponent field width in the encoded posit (>= 0)
- W_REG, 6, signed regime input width; must represent ±(N-1)
- W_EXP, 2, exponent input width (>= ES+1); only bits [ES-1:0] are encoded
- W_MAN, 16, fraction input width, MSB-aligned, hidden bit excluded

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept this cycle
- in_sign  in  sign_t  1 = negative
- in_regime  in  W_REG signed  regime k
- in_exponent  in  W_EXP signed  exponent e, 0..2^ES-1
- in_mantissa  in  W_MAN unsigned  fraction bits, MSB-aligned
- in_zero  in  1  value is zero (overrides fields)
- in_nar  in  1  value is NaR (overrides zero and fields)
- out_valid  out  1  out_posit valid
- out_ready  in  1  downstream accepts
- out_posit  out  N  encoded posit

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: s1_valid, s2_valid and out_valid go to 0; out_posit goes to 0.
  - Reset mid-operation discards all in-flight data; no output is produced for it.
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Ready logic:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, a combinational ready chain with no bubbles.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid.
  - Throughput is 1 per cycle when out_ready stays high.
  - While stalled, out_posit and out_valid hold stable.
- Stage 1 (build body):
  - Regime run length: k >= 0 gives k+1 ones followed by a zero; k < 0 gives -k zeros followed by a one.
  - Concatenate regime, then e[ES-1:0], then the mantissa into an extended unsigned body.
  - Shift so the body MSB sits at bit N-2 of the kept field.
  - Compute the keep bits (N-1), a guard bit (first dropped bit), and sticky (OR of all remaining dropped bits).
  - Saturation flags, with k_max = N-2:
    - k > k_max sets sat_max.
    - k < -k_max sets sat_min.
    - k == k_max gives the all-ones body, with exponent and fraction fully truncated.
- Stage 2 (round, saturate, sign):
  - Round up = guard & (sticky | keep[0]).
  - body' = keep + round_up. A carry ripples into the exponent and regime naturally.
  - Clamp: if body' overflows N-1 bits, or sat_max, use maxpos body (all ones).
  - If sat_min, or body' == 0, use minpos body (0…01). Nonzero values never round to zero.
  - word = {0, body'}. If sign is 1, out_posit = two's complement of word.
  - in_zero gives 0x0…0. in_nar gives 1 followed by zeros, i.e. 0x8000 for N=16.
  - in_nar takes priority over in_zero.
- Width rules:
  - Internal extended body width is N-1+W_MAN+2^ES+2 bits; no information is lost before guard/sticky extraction.
  - All regime arithmetic is signed W_REG+1 bits.
- Simultaneous events:
  - Input transfer and output transfer in the same cycle both proceed.
  - A new input fills s1 while s1 advances into s2.

Decomposition:
- The shared package `common` holds:
  - sign_t (already used by the ALU)
  - the posit_cfg constants N, ES
  - localparams for NaR and zero patterns
  - a function `maxpos_body(N)`
- Sub-module `posit_round` (stage-2 combinational: RNE, clamp, negate) is natural. It is reused by the future decoder-rounding path.
- Stage 1 stays inline.

Test Plan:
- N=16, ES=1: k=0, e=0, man=0x0000, sign=0 → 0x4000; same with sign=1 → 0xC000. out_valid is high exactly 2 cycles after transfer.
- Saturation:
  - k=14 → 0x7FFF.
  - k=20 → 0x7FFF.
  - k=-14 → 0x0001.
  - k=-20 → 0x0001.
  - k=-20 with sign=1 → 0xFFFF.
- RNE:
  - k=0, e=0, man=0x0008 (tie, lsb 0) → 0x4000.
  - man=0x0018 (tie, lsb 1) → 0x4002.
  - man=0x000C (guard plus sticky) → 0x4001.
- Specials: in_zero=1 with arbitrary fields → 0x0000. in_nar=1 and in_zero=1 together → 0x8000.
- Backpressure:
  - Stream 5 back-to-back inputs while out_ready is low for cycles 3–6.
  - in_ready must drop once both stages are full.
  - Outputs appear in order with no loss or duplication; out_posit is stable while stalled.
- Reset: assert rst while both stages are valid. Next cycle out_valid=0 and in_ready=1, and no stale output appears after reset deasserts.
